// File: rtl/id_ex_hazard_ctrl_pkg.sv
// Shared definitions for the ID/EX hazard controller: state encoding,
// the all-zero EX control bundle used for bubbles, and a rem-load helper.
package id_ex_hazard_ctrl_pkg;

  localparam logic [1:0] ST_RUN      = 2'd0;
  localparam logic [1:0] ST_LU_STALL = 2'd1;
  localparam logic [1:0] ST_FLUSH    = 2'd2;

  typedef struct packed {
    logic brz;
    logic brn;
    logic j;
    logic regw;
    logic wai;
    logic memw;
    logic memr;
  } ex_ctrl_t;

  localparam ex_ctrl_t BUBBLE_CTRL = '0;

  // Cycles still owed after the first one, which is spent in RUN itself.
  function automatic logic [2:0] rem_load(input int unsigned cycles);
    return (cycles > 1) ? 3'(cycles - 1) : 3'd0;
  endfunction

endpackage

// File: rtl/id_ex_hazard_ctrl_sat_counter.sv
// Saturating statistics counter with synchronous clear taking priority over increment.
module hazard_sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/id_ex_hazard_ctrl.sv
// Load-use stall and branch/jump flush sequencing for the ID/EX register,
// with saturating counters of stalled cycles and taken control transfers.
module id_ex_hazard_ctrl
  import id_ex_hazard_ctrl_pkg::*;
#(
  parameter int REG_W        = 6,
  parameter int LOAD_STALLS  = 1,
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_W        = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_rs_used,
  input  logic             id_rt_used,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             ex_memr,
  input  logic             ex_regw,
  input  logic             ex_brz,
  input  logic             ex_brn,
  input  logic             ex_j,
  input  logic             ex_zero,
  input  logic             ex_neg,
  input  logic             cnt_clr,
  output logic             pc_write,
  output logic             pc_sel,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             busy,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  localparam logic [2:0] LU_REM    = rem_load(LOAD_STALLS);
  localparam logic [2:0] FLUSH_REM = rem_load(FLUSH_CYCLES);

  logic [1:0] state, state_nxt;
  logic [2:0] rem, rem_nxt;
  logic       take, lu;
  logic       stall_inc, flush_inc;

  assign take = ex_j | (ex_brz & ex_zero) | (ex_brn & ex_neg);
  assign lu   = id_valid & ex_memr & ex_regw &
                ((id_rs_used & (id_rs == ex_rd)) | (id_rt_used & (id_rt == ex_rd)));

  always_comb begin
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    pc_sel      = 1'b0;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    state_nxt   = state;
    rem_nxt     = rem;
    stall_inc   = 1'b0;
    flush_inc   = 1'b0;

    // A taken transfer in EX wins in every state, including mid-stall and mid-flush.
    if (take) begin
      pc_sel      = 1'b1;
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
      flush_inc   = 1'b1;
      state_nxt   = (FLUSH_REM != 3'd0) ? ST_FLUSH : ST_RUN;
      rem_nxt     = FLUSH_REM;
    end else begin
      case (state)
        ST_RUN: begin
          if (lu) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
            stall_inc   = 1'b1;
            state_nxt   = (LU_REM != 3'd0) ? ST_LU_STALL : ST_RUN;
            rem_nxt     = LU_REM;
          end
        end
        ST_LU_STALL: begin
          pc_write    = 1'b0;
          ifid_write  = 1'b0;
          idex_bubble = 1'b1;
          stall_inc   = 1'b1;
          rem_nxt     = rem - 3'd1;
          if (rem <= 3'd1) state_nxt = ST_RUN;
        end
        ST_FLUSH: begin
          ifid_flush  = 1'b1;
          idex_bubble = 1'b1;
          rem_nxt     = rem - 3'd1;
          if (rem <= 3'd1) state_nxt = ST_RUN;
        end
        default: begin
          state_nxt = ST_RUN;
          rem_nxt   = 3'd0;
        end
      endcase
    end

    // While held in reset the pipeline is frozen and fed bubbles/NOPs.
    if (!reset_n) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      pc_sel      = 1'b0;
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_RUN;
      rem   <= 3'd0;
    end else begin
      state <= state_nxt;
      rem   <= rem_nxt;
    end
  end

  assign busy = (state != ST_RUN);

  hazard_sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clock   (clock),
    .reset_n (reset_n),
    .inc     (stall_inc),
    .clr     (cnt_clr),
    .count   (stall_count)
  );

  hazard_sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clock   (clock),
    .reset_n (reset_n),
    .inc     (flush_inc),
    .clr     (cnt_clr),
    .count   (flush_count)
  );

endmodule

// File: tb/tb_id_ex_hazard_ctrl.sv
// Self-checking bench for id_ex_hazard_ctrl: directed scenarios plus random
// traffic compared against a cycle-count reference model of the hazard rules.
module tb_id_ex_hazard_ctrl;

  localparam int REG_W        = 6;
  localparam int LOAD_STALLS  = 2;
  localparam int FLUSH_CYCLES = 3;
  localparam int CNT_W        = 8;
  localparam int CNT_MAX      = (1 << CNT_W) - 1;

  logic             clock;
  logic             reset_n;
  logic             id_valid;
  logic [REG_W-1:0] id_rs, id_rt, ex_rd;
  logic             id_rs_used, id_rt_used;
  logic             ex_memr, ex_regw, ex_brz, ex_brn, ex_j, ex_zero, ex_neg;
  logic             cnt_clr;
  logic             pc_write, pc_sel, ifid_write, ifid_flush, idex_bubble, busy;
  logic [CNT_W-1:0] stall_count, flush_count;

  id_ex_hazard_ctrl #(
    .REG_W(REG_W), .LOAD_STALLS(LOAD_STALLS), .FLUSH_CYCLES(FLUSH_CYCLES), .CNT_W(CNT_W)
  ) dut (
    .clock(clock), .reset_n(reset_n), .id_valid(id_valid),
    .id_rs(id_rs), .id_rt(id_rt), .id_rs_used(id_rs_used), .id_rt_used(id_rt_used),
    .ex_rd(ex_rd), .ex_memr(ex_memr), .ex_regw(ex_regw),
    .ex_brz(ex_brz), .ex_brn(ex_brn), .ex_j(ex_j), .ex_zero(ex_zero), .ex_neg(ex_neg),
    .cnt_clr(cnt_clr), .pc_write(pc_write), .pc_sel(pc_sel),
    .ifid_write(ifid_write), .ifid_flush(ifid_flush), .idex_bubble(idex_bubble),
    .busy(busy), .stall_count(stall_count), .flush_count(flush_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Reference model: cycles owed to an ongoing flush or stall, plus counts.
  int flush_left   = 0;
  int bubbles_left = 0;
  int m_stall      = 0;
  int m_flush      = 0;
  int kind         = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [REG_W-1:0] rs, input logic [REG_W-1:0] rt,
                               input logic rsu, input logic rtu, input logic [REG_W-1:0] rd,
                               input logic memr, input logic regw, input logic brz, input logic brn,
                               input logic j, input logic zero, input logic neg, input logic clr);
    id_valid = v; id_rs = rs; id_rt = rt; id_rs_used = rsu; id_rt_used = rtu; ex_rd = rd;
    ex_memr = memr; ex_regw = regw; ex_brz = brz; ex_brn = brn; ex_j = j;
    ex_zero = zero; ex_neg = neg; cnt_clr = clr;
  endtask

  task automatic applyIdle();
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // kind: 0 normal flow, 1 taken transfer, 2 flush cycle, 3 stall cycle
  task automatic checkOutput(input string tag);
    bit t, l;
    t = ex_j | (ex_brz & ex_zero) | (ex_brn & ex_neg);
    l = id_valid && ex_memr && ex_regw &&
        ((id_rs_used && id_rs == ex_rd) || (id_rt_used && id_rt == ex_rd));
    if (t)                    kind = 1;
    else if (flush_left > 0)  kind = 2;
    else if (bubbles_left > 0) kind = 3;
    else if (l)               kind = 3;
    else                      kind = 0;
    check({tag, ".pc_write"},    32'(pc_write),    32'(kind != 3));
    check({tag, ".ifid_write"},  32'(ifid_write),  32'(kind != 3));
    check({tag, ".pc_sel"},      32'(pc_sel),      32'(kind == 1));
    check({tag, ".ifid_flush"},  32'(ifid_flush),  32'(kind == 1 || kind == 2));
    check({tag, ".idex_bubble"}, 32'(idex_bubble), 32'(kind != 0));
    check({tag, ".busy"},        32'(busy),        32'(flush_left > 0 || bubbles_left > 0));
    check({tag, ".stall_count"}, 32'(stall_count), 32'(m_stall));
    check({tag, ".flush_count"}, 32'(flush_count), 32'(m_flush));
  endtask

  task automatic advanceModel();
    case (kind)
      1: begin
        flush_left   = FLUSH_CYCLES - 1;
        bubbles_left = 0;
        if (m_flush < CNT_MAX) m_flush++;
      end
      2: flush_left--;
      3: begin
        if (bubbles_left > 0) bubbles_left--;
        else bubbles_left = LOAD_STALLS - 1;
        if (m_stall < CNT_MAX) m_stall++;
      end
      default: ;
    endcase
    if (cnt_clr) begin
      m_stall = 0;
      m_flush = 0;
    end
  endtask

  task automatic resetModel();
    flush_left = 0; bubbles_left = 0; m_stall = 0; m_flush = 0; kind = 0;
  endtask

  task automatic runCycle(input string tag);
    @(negedge clock);
    checkOutput(tag);
    @(posedge clock);
    advanceModel();
    #1;
  endtask

  task automatic checkResetOutputs(input string tag);
    check({tag, ".pc_write"},    32'(pc_write),    32'd0);
    check({tag, ".ifid_write"},  32'(ifid_write),  32'd0);
    check({tag, ".pc_sel"},      32'(pc_sel),      32'd0);
    check({tag, ".ifid_flush"},  32'(ifid_flush),  32'd1);
    check({tag, ".idex_bubble"}, 32'(idex_bubble), 32'd1);
    check({tag, ".busy"},        32'(busy),        32'd0);
    check({tag, ".stall_count"}, 32'(stall_count), 32'd0);
    check({tag, ".flush_count"}, 32'(flush_count), 32'd0);
  endtask

  initial begin
    reset_n = 1'b0;
    applyIdle();
    #3;
    checkResetOutputs("reset");
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock);
    #1;
    resetModel();
    runCycle("post_reset");

    $display("[TB] load-use stall");
    applyStimulus(1'b1, 6'd5, 6'd9, 1'b1, 1'b0, 6'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    runCycle("lu_first");
    runCycle("lu_second");
    applyIdle();
    runCycle("lu_release");
    check("lu_stall_count", 32'(stall_count), 32'd2);

    $display("[TB] no false hazard");
    applyStimulus(1'b1, 6'd5, 6'd4, 1'b0, 1'b1, 6'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clock);
    check("nohaz_pc_write", 32'(pc_write), 32'd1);
    check("nohaz_bubble", 32'(idex_bubble), 32'd0);
    runCycle("nohaz");

    $display("[TB] taken branch");
    applyStimulus(1'b1, '0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    runCycle("br_take");
    applyIdle();
    runCycle("br_flush1");
    runCycle("br_flush2");
    runCycle("br_done");
    check("br_flush_count", 32'(flush_count), 32'd1);

    $display("[TB] not-taken branch");
    applyStimulus(1'b1, '0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    runCycle("brn_not_taken");

    $display("[TB] take with load-use");
    applyStimulus(1'b1, 6'd7, 6'd0, 1'b1, 1'b0, 6'd7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    runCycle("take_lu");
    applyIdle();
    runCycle("take_lu_f1");
    runCycle("take_lu_f2");
    check("take_lu_stall_count", 32'(stall_count), 32'd2);

    $display("[TB] reset mid-flush");
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    runCycle("rst_take");
    applyIdle();
    runCycle("rst_flush1");
    reset_n = 1'b0;
    #2;
    checkResetOutputs("mid_flush_reset");
    resetModel();
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock);
    #1;
    runCycle("after_reset");

    $display("[TB] random traffic");
    for (int i = 0; i < 400; i++) begin
      applyStimulus($urandom_range(3, 0) != 0, 6'($urandom_range(3, 0)), 6'($urandom_range(3, 0)),
                    1'($urandom), 1'($urandom), 6'($urandom_range(3, 0)),
                    $urandom_range(1, 0) == 1, $urandom_range(3, 0) != 0,
                    $urandom_range(7, 0) == 0, $urandom_range(7, 0) == 0,
                    $urandom_range(15, 0) == 0, 1'($urandom), 1'($urandom),
                    $urandom_range(31, 0) == 0);
      runCycle("random");
    end

    $display("[TB] saturation and clear");
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < CNT_MAX + 5; i++) runCycle("sat");
    check("sat_flush_count", 32'(flush_count), 32'(CNT_MAX));
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    runCycle("clr_take");
    applyIdle();
    runCycle("after_clr");
    check("clr_flush_count", 32'(flush_count), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
